div_sched: RTL
==============

Name: div_sched

Overview:
- Sequencer between the EX stage and the iterative signed divider.
- Captures DIV operands, issues them to the divider with a one-cycle valid pulse, and stalls EX until the 64-bit result returns.
- Owns the architectural HI/LO registers: HI = remainder, LO = quotient.
- Resolves HI/LO hazards (MFHI/MFLO/MTHI/MTLO during a divide), pipeline flushes mid-divide, divide-by-zero, and a lost-result watchdog.

Parameters:
MAX_WAIT, 40, cycles allowed in WAIT/DRAIN before the watchdog fires (divider nominal: 33 cycles after capture)
CW, 6, width of the wait counter; must hold MAX_WAIT

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
ex_div_req  in  1  EX holds a signed DIV
ex_src_a  in  32  dividend
ex_src_b  in  32  divisor
ex_advance  in  1  EX hands its instruction to MEM this cycle
ex_flush  in  1  exception/flush kills the EX instruction
ex_hilo_rd  in  1  EX holds MFHI or MFLO
hi_we  in  1  MTHI write
lo_we  in  1  MTLO write
hilo_wdata  in  32  MTHI/MTLO data
div_dividend  out  32  to divider, registered
div_divisor  out  32  to divider, registered
div_a_valid  out  1  to divider, registered
div_b_valid  out  1  to divider, registered
div_out  in  64  from divider: {remainder, quotient}
div_validout  in  1  from divider, one-cycle result pulse
hi  out  32  HI register
lo  out  32  LO register
stall  out  1  combinational; holds EX
busy  out  1  state != IDLE
dbz  out  1  one-cycle pulse on divide-by-zero
err  out  1  sticky watchdog error

Behaviour:
- Reset values: div_* = 0, hi = lo = 0, dbz = 0, err = 0, state = IDLE, counter = 0. The divider shares resetn, so reset mid-operation aborts both blocks cleanly.
- States: IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE:
  - ex_div_req && !ex_flush && ex_src_b != 0: latch operands into div_dividend/div_divisor, go to ISSUE.
  - ex_div_req && !ex_flush && ex_src_b == 0: HI/LO unchanged, dbz = 1 for one cycle, go to DONE.
  - ex_flush set: request ignored, stay in IDLE.
  - hi_we/lo_we with no div request: write hi/lo from hilo_wdata at the next edge. A div request has priority over the writes.
- ISSUE (exactly 1 cycle):
  - div_a_valid = div_b_valid = 1; the divider captures at this edge.
  - Next state is WAIT, or DRAIN if ex_flush. Once issued, the divider cannot be aborted.
  - Counter cleared.
- WAIT:
  - Counter increments every cycle.
  - div_validout: hi <= div_out[63:32], lo <= div_out[31:0], go to DONE.
  - ex_flush without validout: go to DRAIN, HI/LO untouched.
  - validout and ex_flush in the same cycle: result discarded, go to IDLE.
- DRAIN:
  - Stays until div_validout, which is discarded; then go to IDLE.
  - New EX requests stall here.
- DONE:
  - stall deasserted for the divide.
  - Go to IDLE on ex_advance or ex_flush; otherwise hold, with no re-issue.
- Watchdog: in WAIT or DRAIN, when counter == MAX_WAIT, set err (sticky until reset) and go to IDLE with HI/LO unchanged.
- stall = (ex_div_req && !ex_flush && state != DONE) || ((ex_hilo_rd || hi_we || lo_we) && state != IDLE && state != DONE).
- Nominal latency: request accepted in cycle 0, ISSUE in cycle 1, div_validout in cycle 34, DONE in cycle 35 with the new hi/lo visible. stall is high for cycles 0–34.
- Arithmetic: the divider is signed-only, so no DIVU here. The remainder takes the dividend's sign.

Decomposition:
- Shared package: state encoding (3-bit localparams S_IDLE..S_DONE) and the HI/LO bit-slice constants.
- No sub-module is needed; the watchdog counter stays inline.
- The divider is instantiated alongside, by the parent.

Test Plan:
- Basic divide: DIV 7 / -2, hold req until advance -> div_a/b_valid high in cycle 1 only; HI = 0x00000001, LO = 0xFFFFFFFD in cycle 35; stall high in cycles 0–34.
- Negative dividend: DIV -7 / 2 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFD. Then MFHI is issued in cycle 10 of a following DIV 100 / 7 -> stall holds until DONE; HI = 2, LO = 14.
- Divide by zero: DIV 5 / 0 with HI = 0x11, LO = 0x22 -> no divider valids, dbz pulses in cycle 0, DONE in cycle 1, HI/LO unchanged.
- Flush mid-divide: ex_flush in cycle 10 of DIV 9 / 3 -> DRAIN. A new DIV 8 / 2 stalls until validout, the first result is discarded, and the new result is HI = 0, LO = 4.
- Watchdog: divider stub never asserts validout -> err rises MAX_WAIT cycles into WAIT, state returns to IDLE, and MTHI 0xABCD is then accepted.
- Reset in cycle 20 of a divide -> all outputs at reset values the next cycle; a new DIV completes with the normal 35-cycle timing.

Source files
------------

// File: rtl/div_sched_pkg.sv
// div_sched_pkg: state encoding and HI/LO slice positions for the divide sequencer
package div_sched_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;
endpackage

// File: rtl/div_sched.sv
// div_sched: issues signed DIVs to the iterative divider, stalls EX and owns HI/LO
module div_sched
  import div_sched_pkg::*;
#(
  parameter int MAX_WAIT = 40,
  parameter int CW       = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_div_req,
  input  logic [31:0] ex_src_a,
  input  logic [31:0] ex_src_b,
  input  logic        ex_advance,
  input  logic        ex_flush,
  input  logic        ex_hilo_rd,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hilo_wdata,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_a_valid,
  output logic        div_b_valid,
  input  logic [63:0] div_out,
  input  logic        div_validout,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        stall,
  output logic        busy,
  output logic        dbz,
  output logic        err
);
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   dividend_q, dividend_d, divisor_q, divisor_d, hi_q, hi_d, lo_q, lo_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          req, timeout;
  assign req     = ex_div_req && !ex_flush;
  assign timeout = cnt_q == CW'(MAX_WAIT);
  // next-state, operand capture, HI/LO update and watchdog
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && ex_src_b != 32'd0) begin
          state_d    = S_ISSUE;
          dividend_d = ex_src_a;
          divisor_d  = ex_src_b;
          valid_d    = 1'b1;
        end else if (req) begin
          state_d = S_DONE;
        end else if (!ex_div_req) begin
          hi_d = hi_we ? hilo_wdata : hi_q;
          lo_d = lo_we ? hilo_wdata : lo_q;
        end
      end
      S_ISSUE: begin
        state_d = ex_flush ? S_DRAIN : S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (div_validout) begin
          state_d = ex_flush ? S_IDLE : S_DONE;
          hi_d    = ex_flush ? hi_q : div_out[HI_MSB:HI_LSB];
          lo_d    = ex_flush ? lo_q : div_out[LO_MSB:LO_LSB];
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (ex_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (div_validout) begin
          state_d = S_IDLE;
        end else if (timeout) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end
      end
      S_DONE: state_d = (ex_advance || ex_flush) ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered divider-side outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign div_a_valid  = valid_q;
  assign div_b_valid  = valid_q;
  assign hi           = hi_q;
  assign lo           = lo_q;
  assign err          = err_q;
  assign busy         = state_q != S_IDLE;
  assign dbz          = state_q == S_IDLE && req && ex_src_b == 32'd0;
  assign stall        = (req && state_q != S_DONE) ||
                        ((ex_hilo_rd || hi_we || lo_we) && state_q != S_IDLE && state_q != S_DONE);
endmodule
